// File: rtl/tx_frame_scheduler_if.sv
// Source-side and Transmitter-side signals of the two-requester frame scheduler.
// master = sources/transmitter environment, slave = the scheduler itself.
interface tx_frame_scheduler_if;
  logic       Req0, Req1;
  logic       Grant0, Grant1;
  logic [7:0] Data0, Data1;
  logic       DataValid0, DataValid1;
  logic       DataReady0, DataReady1;
  logic       TxStart, TxInput, TxReset;
  logic       Busy, FrameDone, Underrun;

  modport master (
    output Req0, Req1, Data0, Data1, DataValid0, DataValid1,
    input  Grant0, Grant1, DataReady0, DataReady1,
           TxStart, TxInput, TxReset, Busy, FrameDone, Underrun
  );

  modport slave (
    input  Req0, Req1, Data0, Data1, DataValid0, DataValid1,
    output Grant0, Grant1, DataReady0, DataReady1,
           TxStart, TxInput, TxReset, Busy, FrameDone, Underrun
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// Round-robin frame scheduler feeding PSDU bits LSB-first into the 802.11a Transmitter.
// Optional: define TX_SCHED_UNDERRUN_ABORT_EN to abort the frame on the first byte underrun.
module tx_frame_scheduler #(
  parameter int FRAME_OCTETS = 16,
  parameter int PSDU_OFFSET  = 140,
  parameter int FLUSH_CYCLES = 32,
  parameter int IFS_CYCLES   = 16
) (
  input logic                 Clock,
  input logic                 Reset,
  tx_frame_scheduler_if.slave bus
);
  localparam logic [15:0] LAST_HDR   = 16'(PSDU_OFFSET - 1);
  localparam logic [15:0] FIRST_PSDU = 16'(PSDU_OFFSET);
  localparam logic [15:0] LAST_PSDU  = 16'(PSDU_OFFSET + 8*FRAME_OCTETS - 1);
  localparam logic [15:0] LAST_FLUSH = 16'(PSDU_OFFSET + 8*FRAME_OCTETS + FLUSH_CYCLES - 1);
  localparam logic [15:0] LAST_GAP   = 16'(IFS_CYCLES);

  typedef enum logic [2:0] {IDLE, ARB, START, HEADER, PSDU, FLUSH, GAP} state_t;

  state_t      state_q, state_n;
  logic [15:0] cnt_q, cnt_n, rel_n;
  logic [7:0]  shreg_q, shreg_n, fetch_data;
  logic [1:0]  grant_q, grant_n;
  logic [1:0]  dr_q, dr_n;
  logic        last_grant_q, last_grant_n;
  logic        underrun_q, underrun_n;
  logic        tx_start_q, tx_input_q, busy_q, frame_done_q;
  logic        fetch_valid, byte_miss, abort, winner1;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_n;
  end

  // cnt holds the index of the edge that ends the current cycle (edge 0 ends START)
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    grant_n      = grant_q;
    last_grant_n = last_grant_q;
    underrun_n   = underrun_q;
    winner1      = 1'b0;
    fetch_valid  = dr_q[1] ? bus.DataValid1 : bus.DataValid0;
    fetch_data   = dr_q[1] ? bus.Data1 : bus.Data0;
    byte_miss    = (|dr_q) & ~fetch_valid;
`ifdef TX_SCHED_UNDERRUN_ABORT_EN
    abort        = byte_miss;
`else
    abort        = 1'b0;
`endif
    if (|dr_q)                 shreg_n = fetch_valid ? fetch_data : 8'h00;
    else if (state_q == PSDU)  shreg_n = {1'b0, shreg_q[7:1]};
    else                       shreg_n = shreg_q;
    if (byte_miss) underrun_n = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_n = 16'd0;
        if (bus.Req0 | bus.Req1) state_n = ARB;
      end
      ARB: begin
        if (bus.Req0 | bus.Req1) begin
          winner1      = (bus.Req0 & bus.Req1) ? ~last_grant_q : bus.Req1;
          grant_n      = winner1 ? 2'b10 : 2'b01;
          last_grant_n = winner1;
          underrun_n   = 1'b0;
          state_n      = START;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        cnt_n   = 16'd1;
        state_n = HEADER;
      end
      HEADER: begin
        cnt_n = cnt_q + 16'd1;
        if (cnt_q == LAST_HDR) state_n = PSDU;
      end
      PSDU: begin
        cnt_n = cnt_q + 16'd1;
        if (cnt_q == LAST_PSDU) state_n = FLUSH;
      end
      FLUSH: begin
        cnt_n = cnt_q + 16'd1;
        if (cnt_q == LAST_FLUSH) begin
          cnt_n = 16'd1;
          if (IFS_CYCLES == 0) state_n = IDLE;
          else                 state_n = GAP;
        end
      end
      GAP: begin
        cnt_n = cnt_q + 16'd1;
        if (cnt_q == LAST_GAP) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      cnt_n = 16'd1;
      if (IFS_CYCLES == 0) state_n = IDLE;
      else                 state_n = GAP;
    end
    if (state_n == IDLE) grant_n = 2'b00;

    // byte fetch strobes line up with the edge before each byte's first bit
    rel_n = cnt_n - FIRST_PSDU;
    dr_n  = 2'b00;
    if ((state_n == HEADER && cnt_n == LAST_HDR) ||
        (state_n == PSDU && rel_n[2:0] == 3'd7 && cnt_n != LAST_PSDU))
      dr_n = grant_n;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt_q        <= 16'd0;
      shreg_q      <= 8'h00;
      grant_q      <= 2'b00;
      dr_q         <= 2'b00;
      last_grant_q <= 1'b1;
      underrun_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_input_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_n;
      shreg_q      <= shreg_n;
      grant_q      <= grant_n;
      dr_q         <= dr_n;
      last_grant_q <= last_grant_n;
      underrun_q   <= underrun_n;
      tx_start_q   <= (state_n == START);
      tx_input_q   <= (state_n == PSDU) & shreg_n[0];
      busy_q       <= (state_n != IDLE);
      frame_done_q <= (state_n == FLUSH) && (cnt_n == LAST_FLUSH);
    end
  end

`ifdef TX_SCHED_UNDERRUN_ABORT_EN
  logic tx_reset_q;
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) tx_reset_q <= 1'b0;
    else        tx_reset_q <= abort;
  end
  assign bus.TxReset = tx_reset_q;
`else
  assign bus.TxReset = 1'b0;
`endif

  assign bus.Grant0     = grant_q[0];
  assign bus.Grant1     = grant_q[1];
  assign bus.DataReady0 = dr_q[0];
  assign bus.DataReady1 = dr_q[1];
  assign bus.TxStart    = tx_start_q;
  assign bus.TxInput    = tx_input_q;
  assign bus.Busy       = busy_q;
  assign bus.FrameDone  = frame_done_q;
  assign bus.Underrun   = underrun_q;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Self-checking bench for tx_frame_scheduler: frame timeline model derived from edge arithmetic.
module tb_tx_frame_scheduler;
  localparam int F   = 16;
  localparam int P   = 140;
  localparam int FC  = 32;
  localparam int IFS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_frame_scheduler_if bus();

  tx_frame_scheduler #(
    .FRAME_OCTETS(F), .PSDU_OFFSET(P), .FLUSH_CYCLES(FC), .IFS_CYCLES(IFS)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [2][F];
  bit         vld [2][F];
  int         strobes [2];
  int         base [2];
  bit         dr_seen [2];
  int         model_last = 1;
  bit         model_und  = 1'b0;

  // byte sources: present byte (strobes - base) and advance after each accepted strobe
  initial begin
    strobes[0] = 0; strobes[1] = 0;
  end
  always begin
    @(negedge clk);
    dr_seen[0] = bus.DataReady0;
    dr_seen[1] = bus.DataReady1;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) if (dr_seen[s]) strobes[s]++;
    if (strobes[0] - base[0] >= 0 && strobes[0] - base[0] < F) begin
      bus.Data0 = mem[0][strobes[0] - base[0]]; bus.DataValid0 = vld[0][strobes[0] - base[0]];
    end else begin
      bus.Data0 = 8'($urandom); bus.DataValid0 = 1'($urandom);
    end
    if (strobes[1] - base[1] >= 0 && strobes[1] - base[1] < F) begin
      bus.Data1 = mem[1][strobes[1] - base[1]]; bus.DataValid1 = vld[1][strobes[1] - base[1]];
    end else begin
      bus.Data1 = 8'($urandom); bus.DataValid1 = 1'($urandom);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int pick_winner(input bit r0, input bit r1);
    if (r0 && r1) return (model_last == 1) ? 0 : 1;
    return r1 ? 1 : 0;
  endfunction

  // One frame against the edge-numbered timeline; t0 is the START cycle (ends at edge 0).
  task automatic run_frame(input int src, input int t0, input int miss, input int stop_k,
                           input bit drop, input bit seq, output int last);
    int k, miss_k, done_k, j, i;
    bit aborted;
    logic [7:0] b;
    bit e_start, e_busy, e_g0, e_g1, e_dr0, e_dr1, e_tx, e_done, e_und, e_rst, e_g, e_dr;
    for (int n = 0; n < F; n++) begin
      mem[src][n] = seq ? 8'(n + 1) : 8'($urandom);
      vld[src][n] = (n != miss);
    end
    base[src] = strobes[src];
    miss_k  = (miss >= 0) ? P - 1 + 8*miss : 32'h3fffffff;
    aborted = 1'b0;
`ifdef TX_SCHED_UNDERRUN_ABORT_EN
    aborted = (miss >= 0);
`endif
    done_k = P + 8*F + FC - 1;
    last   = aborted ? miss_k + IFS : done_k + IFS;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      k = cyc - t0;
      if (k >= -1) begin
        e_busy  = (k <= last);
        e_g     = (k >= 0) && (k <= last);
        e_g0    = e_g && (src == 0);
        e_g1    = e_g && (src == 1);
        e_start = (k == 0);
        e_dr    = (k >= P - 1) && (k <= P - 1 + 8*(F - 1)) && ((k - (P - 1)) % 8 == 0)
                  && !(aborted && k > miss_k);
        e_dr0   = e_dr && (src == 0);
        e_dr1   = e_dr && (src == 1);
        e_tx    = 1'b0;
        if (k >= P && k <= P + 8*F - 1 && !(aborted && k > miss_k)) begin
          j = (k - P) / 8;
          i = (k - P) % 8;
          b = (j == miss) ? 8'h00 : mem[src][j];
          e_tx = b[i];
        end
        e_done = !aborted && (k == done_k);
        e_rst  = aborted && (k == miss_k + 1);
        e_und  = (k < 0) ? model_und : (k > miss_k);

        total++; if (bus.TxStart !== e_start) begin bad++; $display("FAIL txstart k=%0d got=%b exp=%b", k, bus.TxStart, e_start); end
        total++; if (bus.Busy !== e_busy) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, bus.Busy, e_busy); end
        total++; if (bus.Grant0 !== e_g0) begin bad++; $display("FAIL grant0 k=%0d got=%b exp=%b", k, bus.Grant0, e_g0); end
        total++; if (bus.Grant1 !== e_g1) begin bad++; $display("FAIL grant1 k=%0d got=%b exp=%b", k, bus.Grant1, e_g1); end
        total++; if (bus.DataReady0 !== e_dr0) begin bad++; $display("FAIL dataready0 k=%0d got=%b exp=%b", k, bus.DataReady0, e_dr0); end
        total++; if (bus.DataReady1 !== e_dr1) begin bad++; $display("FAIL dataready1 k=%0d got=%b exp=%b", k, bus.DataReady1, e_dr1); end
        total++; if (bus.TxInput !== e_tx) begin bad++; $display("FAIL txinput k=%0d got=%b exp=%b", k, bus.TxInput, e_tx); end
        total++; if (bus.FrameDone !== e_done) begin bad++; $display("FAIL framedone k=%0d got=%b exp=%b", k, bus.FrameDone, e_done); end
        total++; if (bus.Underrun !== e_und) begin bad++; $display("FAIL underrun k=%0d got=%b exp=%b", k, bus.Underrun, e_und); end
        total++; if (bus.TxReset !== e_rst) begin bad++; $display("FAIL txreset k=%0d got=%b exp=%b", k, bus.TxReset, e_rst); end
      end
      if (k == 1 && drop) begin
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
      end
      if (k > last || (stop_k >= 0 && k >= stop_k)) break;
    end
    model_und = (miss >= 0);
  endtask

  task automatic start_req(input bit r0, input bit r1, output int t0, output int w);
    @(posedge clk);
    #1;
    bus.Req0 = r0;
    bus.Req1 = r1;
    t0 = cyc + 2;
    w = pick_winner(r0, r1);
    model_last = w;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    rst_n = 1'b0;
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.Grant0, bus.Grant1, bus.DataReady0, bus.DataReady1, bus.TxStart,
            bus.TxInput, bus.TxReset, bus.Busy, bus.FrameDone, bus.Underrun};
    total++; if (outs !== 10'd0) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", outs, 10'd0); end
    rst_n = 1'b1;
    model_last = 1;
    model_und = 1'b0;
    repeat (2) @(negedge clk);
    outs = {bus.Grant0, bus.Grant1, bus.DataReady0, bus.DataReady1, bus.TxStart,
            bus.TxInput, bus.TxReset, bus.Busy, bus.FrameDone, bus.Underrun};
    total++; if (outs !== 10'd0) begin bad++; $display("FAIL idle_after_reset got=%b exp=%b", outs, 10'd0); end
  endtask

  task automatic test_back_to_back();
    int t0, w, last;
    start_req(1'b1, 1'b1, t0, w);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        w = pick_winner(1'b1, 1'b1);
        model_last = w;
      end
      run_frame(w, t0, -1, -1, (f == 2), 1'b0, last);
      t0 = t0 + last + 3;
    end
  endtask

  task automatic test_basic();
    int t0, w, last;
    start_req(1'b1, 1'b0, t0, w);
    run_frame(w, t0, -1, -1, 1'b1, 1'b1, last);
  endtask

  task automatic test_req_pulse();
    int t0, w, last;
    start_req(1'b1, 1'b0, t0, w);
    fork
      run_frame(w, t0, -1, -1, 1'b1, 1'b0, last);
      begin
        repeat (60) @(posedge clk);
        #1 bus.Req1 = 1'b1;
        @(posedge clk);
        #1 bus.Req1 = 1'b0;
      end
    join
    repeat (20) begin
      @(negedge clk);
      total++;
      if ({bus.Busy, bus.Grant0, bus.Grant1} !== 3'b000) begin
        bad++; $display("FAIL no_regrant got=%b exp=%b", {bus.Busy, bus.Grant0, bus.Grant1}, 3'b000);
      end
    end
  endtask

  task automatic test_underrun();
    int t0, w, last;
    start_req(1'b1, 1'b0, t0, w);
    run_frame(w, t0, 5, -1, 1'b1, 1'b0, last);
    repeat (5) @(negedge clk);
    total++; if (bus.Underrun !== 1'b1) begin bad++; $display("FAIL underrun_sticky got=%b exp=1", bus.Underrun); end
    start_req(1'b0, 1'b1, t0, w);
    run_frame(w, t0, -1, -1, 1'b1, 1'b0, last);
  endtask

  task automatic test_async_reset();
    int t0, w, last;
    logic [9:0] outs;
    start_req(1'b1, 1'b0, t0, w);
    run_frame(w, t0, -1, 200, 1'b1, 1'b0, last);
    rst_n = 1'b0;
    #1;
    outs = {bus.Grant0, bus.Grant1, bus.DataReady0, bus.DataReady1, bus.TxStart,
            bus.TxInput, bus.TxReset, bus.Busy, bus.FrameDone, bus.Underrun};
    total++; if (outs !== 10'd0) begin bad++; $display("FAIL async_reset_outputs got=%b exp=%b", outs, 10'd0); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    model_und = 1'b0;
    start_req(1'b1, 1'b1, t0, w);
    run_frame(w, t0, -1, -1, 1'b1, 1'b0, last);
  endtask

  task automatic test_random();
    int t0, w, last, r, miss;
    for (int f = 0; f < 4; f++) begin
      r = $urandom_range(1, 3);
      miss = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, F - 1)) : -1;
      start_req(r[0], r[1], t0, w);
      run_frame(w, t0, miss, -1, 1'b1, 1'b0, last);
    end
  endtask

  initial begin
    bus.Req0 = 1'b0;
    bus.Req1 = 1'b0;
    base[0] = 0;
    base[1] = 0;
    for (int s = 0; s < 2; s++)
      for (int n = 0; n < F; n++) begin
        mem[s][n] = 8'($urandom);
        vld[s][n] = 1'($urandom);
      end
    test_reset();
    test_back_to_back();
    test_basic();
    test_req_pulse();
    test_underrun();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
